// File: rtl/ripple_borrow_subtractor_seq.sv
// Multi-cycle ripple-borrow subtractor: result = min - sub - borrow_in, one Chunk-bit slice per clock,
// LSB slice first. Optional macro SUB_OVERFLOW_FLAG_EN adds a two's-complement overflow flag ovf_o.
module ripple_borrow_subtractor_seq #(
  parameter int unsigned Width = 16,
  parameter int unsigned Chunk = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [Width-1:0] min_i,
  input  logic [Width-1:0] sub_i,
  input  logic             borrow_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] result_o,
  output logic             borrow_o
`ifdef SUB_OVERFLOW_FLAG_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int unsigned NumSlices = Width / Chunk;
  localparam int unsigned CntW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;
  localparam logic [CntW-1:0] LastSlice = CntW'(NumSlices - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] min_q, min_d;
  logic [Width-1:0] sub_q, sub_d;
  logic [Width-1:0] result_q, result_d;
  logic             borrow_q, borrow_d;
  logic             borrow_out_q, borrow_out_d;
  logic [Chunk-1:0] min_slice, sub_slice;
  logic [Chunk:0]   diff;
  logic             load;

`ifdef SUB_OVERFLOW_FLAG_EN
  logic ovf_q, ovf_d;
`endif

  assign min_slice = min_q[cnt_q*Chunk +: Chunk];
  assign sub_slice = sub_q[cnt_q*Chunk +: Chunk];
  // Extra top bit of the Chunk+1 bit difference is the borrow out of this slice.
  assign diff = {1'b0, min_slice} - {1'b0, sub_slice} - {{Chunk{1'b0}}, borrow_q};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    min_d        = min_q;
    sub_d        = sub_q;
    result_d     = result_q;
    borrow_d     = borrow_q;
    borrow_out_d = borrow_out_q;
    load         = 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
    ovf_d        = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        load = start_i;
      end
      StRun: begin
        result_d[cnt_q*Chunk +: Chunk] = diff[Chunk-1:0];
        borrow_d = diff[Chunk];
        if (cnt_q == LastSlice) begin
          state_d      = StDone;
          borrow_out_d = diff[Chunk];
`ifdef SUB_OVERFLOW_FLAG_EN
          // diff[Chunk-1] is the result MSB once the top slice is computed.
          ovf_d = (min_q[Width-1] != sub_q[Width-1]) && (diff[Chunk-1] != min_q[Width-1]);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        load    = start_i;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      state_d  = StRun;
      cnt_d    = '0;
      min_d    = min_i;
      sub_d    = sub_i;
      borrow_d = borrow_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      min_q        <= '0;
      sub_q        <= '0;
      result_q     <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      min_q        <= min_d;
      sub_q        <= sub_d;
      result_q     <= result_d;
      borrow_q     <= borrow_d;
      borrow_out_q <= borrow_out_d;
    end
  end

`ifdef SUB_OVERFLOW_FLAG_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`endif

  assign busy_o   = (state_q == StRun);
  assign done_o   = (state_q == StDone);
  assign result_o = result_q;
  assign borrow_o = borrow_out_q;

endmodule
